// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the perceptron-array control path: state encoding,
// default sizes and parameter-address helpers.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_P   = 3'd1,
    ST_LOAD_I   = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_FEEDBACK = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam int NUM_PARAMS_DEF = 20;
  localparam int NUM_INPUTS_DEF = 4;
  localparam int NEURONS        = 4;

  // Each neuron owns NEURONS weights followed by one bias byte.
  localparam int PARAM_STRIDE  = NEURONS + 1;
  localparam int BIAS_OFFSET   = NEURONS;
  localparam int PARAM_ADDR_W  = 5;
  localparam int INPUT_ADDR_W  = $clog2(NEURONS);

  // Parameter index of weight w<n><i>.
  function automatic logic [PARAM_ADDR_W-1:0] weight_addr(input int n, input int i);
    return PARAM_ADDR_W'(n * PARAM_STRIDE + i);
  endfunction

  // Parameter index of bias b<n> (5n+4).
  function automatic logic [PARAM_ADDR_W-1:0] bias_addr(input int n);
    return PARAM_ADDR_W'(n * PARAM_STRIDE + BIAS_OFFSET);
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control bundle between the layer sequencer and its requester / register files.
interface nn_layer_sequencer_if;
  import nn_ctrl_pkg::*;

  logic                    byte_valid;
  logic                    load_params;
  logic                    run;
  logic                    param_we;
  logic [PARAM_ADDR_W-1:0] param_addr;
  logic                    input_we;
  logic [INPUT_ADDR_W-1:0] input_addr;
  logic                    feedback_we;
  logic                    out_we;
  logic                    busy;
  logic                    done;
  logic                    params_ok;
  logic [2:0]              state;

  // Requester side: drives the bus strobe and the requests.
  modport master (
    output byte_valid, load_params, run,
    input  param_we, param_addr, input_we, input_addr, feedback_we,
    input  out_we, busy, done, params_ok, state
  );

  // Sequencer side.
  modport slave (
    input  byte_valid, load_params, run,
    output param_we, param_addr, input_we, input_addr, feedback_we,
    output out_we, busy, done, params_ok, state
  );

endinterface

// File: rtl/nn_layer_sequencer.sv
// Control FSM for the 4-neuron perceptron array: serial parameter / input
// loading, multi-pass evaluation with output feedback, and final capture.
// Write enables are decoded from registered state plus byte_valid so bytes
// are written in the cycle they appear on the bus.
module nn_layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int PASSES     = 2,
  parameter int SETTLE     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nn_layer_sequencer_if.slave  bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [PARAM_ADDR_W-1:0] LAST_PARAM  = PARAM_ADDR_W'(NUM_PARAMS - 1);
  localparam logic [PARAM_ADDR_W-1:0] LAST_INPUT  = PARAM_ADDR_W'(NUM_INPUTS - 1);
  localparam logic [SW-1:0]           SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [PW-1:0]           LAST_PASS   = PW'(PASSES - 1);

  state_t                  state_r, state_s;
  logic [PARAM_ADDR_W-1:0] byte_cnt_r, byte_cnt_s;
  logic [SW-1:0]           settle_cnt_r, settle_cnt_s;
  logic [PW-1:0]           pass_cnt_r, pass_cnt_s;
  logic                    params_ok_r, params_ok_s;

  logic                    param_we_s;
  logic [PARAM_ADDR_W-1:0] param_addr_s;
  logic                    input_we_s;
  logic [INPUT_ADDR_W-1:0] input_addr_s;
  logic                    feedback_we_s;
  logic                    out_we_s;
  logic                    busy_s;
  logic                    done_s;

  // State and counter registers; reset discards all progress and params_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      byte_cnt_r   <= '0;
      settle_cnt_r <= '0;
      pass_cnt_r   <= '0;
      params_ok_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_cnt_r   <= byte_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      pass_cnt_r   <= pass_cnt_s;
      params_ok_r  <= params_ok_s;
    end
  end

  // Next-state and counter update; requests are only honoured in IDLE.
  always_comb begin
    state_s      = state_r;
    byte_cnt_s   = byte_cnt_r;
    settle_cnt_s = settle_cnt_r;
    pass_cnt_s   = pass_cnt_r;
    params_ok_s  = params_ok_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load_params) begin
          // A new parameter load invalidates the previous set until complete.
          state_s     = ST_LOAD_P;
          params_ok_s = 1'b0;
          byte_cnt_s  = '0;
        end else if (bus.run && params_ok_r) begin
          state_s    = ST_LOAD_I;
          byte_cnt_s = '0;
          pass_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_P: begin
        if (bus.byte_valid) begin
          if (byte_cnt_r == LAST_PARAM) begin
            state_s     = ST_IDLE;
            params_ok_s = 1'b1;
            byte_cnt_s  = '0;
          end else begin
            byte_cnt_s = byte_cnt_r + 5'd1;
          end
        end else begin
          byte_cnt_s = byte_cnt_r;
        end
      end
      ST_LOAD_I: begin
        if (bus.byte_valid) begin
          if (byte_cnt_r == LAST_INPUT) begin
            state_s      = ST_SETTLE;
            settle_cnt_s = SETTLE_LOAD;
            byte_cnt_s   = '0;
          end else begin
            byte_cnt_s = byte_cnt_r + 5'd1;
          end
        end else begin
          byte_cnt_s = byte_cnt_r;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == '0) begin
          if (pass_cnt_r == LAST_PASS) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_FEEDBACK;
          end
        end else begin
          settle_cnt_s = settle_cnt_r - SW'(1);
        end
      end
      ST_FEEDBACK: begin
        state_s      = ST_SETTLE;
        settle_cnt_s = SETTLE_LOAD;
        pass_cnt_s   = pass_cnt_r + PW'(1);
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state/counters; byte_valid gates only the writes.
  always_comb begin
    param_we_s    = 1'b0;
    param_addr_s  = '0;
    input_we_s    = 1'b0;
    input_addr_s  = '0;
    feedback_we_s = 1'b0;
    out_we_s      = 1'b0;
    done_s        = 1'b0;
    busy_s        = (state_r != ST_IDLE);
    case (state_r)
      ST_LOAD_P: begin
        param_we_s   = bus.byte_valid;
        param_addr_s = byte_cnt_r;
      end
      ST_LOAD_I: begin
        input_we_s   = bus.byte_valid;
        input_addr_s = byte_cnt_r[INPUT_ADDR_W-1:0];
      end
      ST_FEEDBACK: begin
        feedback_we_s = 1'b1;
      end
      ST_DONE: begin
        out_we_s = 1'b1;
        done_s   = 1'b1;
      end
      default: begin
        param_we_s = 1'b0;
      end
    endcase
  end

  assign bus.param_we    = param_we_s;
  assign bus.param_addr  = param_addr_s;
  assign bus.input_we    = input_we_s;
  assign bus.input_addr  = input_addr_s;
  assign bus.feedback_we = feedback_we_s;
  assign bus.out_we      = out_we_s;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.params_ok   = params_ok_r;
  assign bus.state       = state_r;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: default configuration (dut_a) and
// PASSES=3 / SETTLE=2 (dut_b) driven from one clock and reset.
module tb_nn_layer_sequencer;
  import nn_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       pwe;
    logic [4:0] pa;
    logic       iwe;
    logic [1:0] ia;
    logic       fwe;
    logic       owe;
    logic       busy;
    logic       done;
    logic       pok;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  nn_layer_sequencer_if ifa ();
  nn_layer_sequencer_if ifb ();

  always #5 clk = ~clk;

  nn_layer_sequencer #(.NUM_PARAMS(20), .NUM_INPUTS(4), .PASSES(2), .SETTLE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  nn_layer_sequencer #(.NUM_PARAMS(20), .NUM_INPUTS(4), .PASSES(3), .SETTLE(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic set_in(input bit sel, input logic lp, input logic rn, input logic bv);
    if (!sel) begin
      ifa.load_params = lp; ifa.run = rn; ifa.byte_valid = bv;
    end else begin
      ifb.load_params = lp; ifb.run = rn; ifb.byte_valid = bv;
    end
  endtask

  function automatic obs_t obs(input bit sel);
    obs_t o;
    if (!sel)
      o = {ifa.state, ifa.param_we, ifa.param_addr, ifa.input_we, ifa.input_addr,
           ifa.feedback_we, ifa.out_we, ifa.busy, ifa.done, ifa.params_ok};
    else
      o = {ifb.state, ifb.param_we, ifb.param_addr, ifb.input_we, ifb.input_addr,
           ifb.feedback_we, ifb.out_we, ifb.busy, ifb.done, ifb.params_ok};
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    #12;
    for (int s = 0; s < 2; s++) begin
      o = obs(s[0]);
      checks++;
      if (o !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %h expected 00000", s, o);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
  endtask

  // Pulse run (params_ok=0) and confirm nothing happens.
  task automatic test_run_ignored(input string tag);
    obs_t o;
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      o = obs(1'b0);
      checks++;
      if (o.st !== 3'd0 || o.iwe !== 1'b0 || o.done !== 1'b0 || o.busy !== 1'b0 || o.pok !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d: state=%0d iwe=%b done=%b busy=%b ok=%b expected 0 0 0 0 0",
                 tag, k, o.st, o.iwe, o.done, o.busy, o.pok);
      end
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full parameter load with 20 back-to-back bytes; optionally run asserted with the request.
  task automatic do_load(input bit sel, input bit both);
    obs_t o;
    set_in(sel, 1'b1, both, 1'b0);
    @(negedge clk);
    o = obs(sel);
    checks++;
    if (o.st !== 3'd0 || o.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_start dut%0d: state=%0d busy=%b expected 0 0", sel, o.st, o.busy);
    end
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      set_in(sel, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o.st !== 3'd1 || o.pwe !== 1'b1 || o.pa !== 5'(i) || o.iwe !== 1'b0 || o.pok !== 1'b0) begin
        errors++;
        $display("FAIL load_byte%0d dut%0d: state=%0d pwe=%b addr=%0d iwe=%b ok=%b expected 1 1 %0d 0 0",
                 i, sel, o.st, o.pwe, o.pa, o.iwe, o.pok, i);
      end
      next_cycle();
    end
    set_in(sel, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    o = obs(sel);
    checks++;
    if (o.st !== 3'd0 || o.pok !== 1'b1 || o.pwe !== 1'b0 || o.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_end dut%0d: state=%0d ok=%b pwe=%b busy=%b expected 0 1 0 0",
               sel, o.st, o.pok, o.pwe, o.busy);
    end
    next_cycle();
  endtask

  // Run: 4 input bytes separated by gap idle cycles, then the compute sequence.
  task automatic do_run(input bit sel, input int gap, input int passes, input int settle,
                        input bit disturb);
    obs_t o;
    int   n;
    bit   fb, dn;
    logic [2:0] est;
    n = passes * (settle + 1);
    set_in(sel, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    o = obs(sel);
    checks++;
    if (o.st !== 3'd0 || o.busy !== 1'b0 || o.done !== 1'b0 || o.pok !== 1'b1) begin
      errors++;
      $display("FAIL run_start dut%0d: state=%0d busy=%b done=%b ok=%b expected 0 0 0 1",
               sel, o.st, o.busy, o.done, o.pok);
    end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        set_in(sel, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        o = obs(sel);
        checks++;
        if (o.st !== 3'd2 || o.iwe !== 1'b0 || o.pwe !== 1'b0) begin
          errors++;
          $display("FAIL input_gap%0d dut%0d: state=%0d iwe=%b pwe=%b expected 2 0 0",
                   i, sel, o.st, o.iwe, o.pwe);
        end
        next_cycle();
      end
      set_in(sel, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o.st !== 3'd2 || o.iwe !== 1'b1 || o.ia !== 2'(i) || o.pwe !== 1'b0) begin
        errors++;
        $display("FAIL input_byte%0d dut%0d: state=%0d iwe=%b addr=%0d pwe=%b expected 2 1 %0d 0",
                 i, sel, o.st, o.iwe, o.ia, o.pwe, i);
      end
      next_cycle();
    end
    for (int c = 1; c <= n; c++) begin
      if (disturb && c < n) set_in(sel, c % 2 == 1, c % 2 == 0, 1'b1);
      else                  set_in(sel, 1'b0, 1'b0, 1'b0);
      fb  = (c % (settle + 1) == 0) && (c != n);
      dn  = (c == n);
      est = dn ? 3'd5 : (fb ? 3'd4 : 3'd3);
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o.st !== est || o.fwe !== fb || o.done !== dn || o.owe !== dn ||
          o.pwe !== 1'b0 || o.iwe !== 1'b0 || o.busy !== 1'b1) begin
        errors++;
        $display("FAIL compute_cyc%0d dut%0d: state=%0d fwe=%b done=%b owe=%b pwe=%b iwe=%b busy=%b expected %0d %b %b %b 0 0 1",
                 c, sel, o.st, o.fwe, o.done, o.owe, o.pwe, o.iwe, o.busy, est, fb, dn, dn);
      end
      next_cycle();
    end
    set_in(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_param_load();
    do_load(1'b0, 1'b0);
    do_load(1'b1, 1'b0);
  endtask

  task automatic test_run_default();
    do_run(1'b0, 2, 2, 1, 1'b0);
  endtask

  task automatic test_run_long();
    do_run(1'b1, 0, 3, 2, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_run(1'b0, 0, 2, 1, 1'b1);
    do_run(1'b1, 1, 3, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_run(1'b0, 0, 2, 1, 1'b0);
    do_run(1'b0, 0, 2, 1, 1'b0);
    @(negedge clk);
    checks++;
    if (ifa.state !== 3'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: state=%0d busy=%b done=%b expected 0 0 0", ifa.state, ifa.busy, ifa.done);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_load();
    obs_t o;
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (ifa.state !== 3'd1 || ifa.param_addr !== 5'd7) begin
      errors++;
      $display("FAIL pre_reset: state=%0d addr=%0d expected 1 7", ifa.state, ifa.param_addr);
    end
    rst_n = 1'b0;
    #1;
    o = obs(1'b0);
    checks++;
    if (o !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid_load: got %h expected 00000", o);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    test_run_ignored("run_after_reset");
  endtask

  task automatic test_both_requests();
    do_load(1'b0, 1'b1);
    do_run(1'b0, 0, 2, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_run_ignored("run_no_params");
    test_param_load();
    test_run_default();
    test_run_long();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_load();
    test_both_requests();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Control FSM for the 4-neuron perceptron array. It sequences serial loading of the 20 parameter bytes (w00..w03, b0, …, w30..w33, b3) and the 4 input bytes from the shared 8-bit input bus. It then runs the array for a configurable number of passes, feeding neuron outputs back as the next pass's inputs, and commands capture of the final outputs. It drives the write enables and addresses of the parameter and input register files; it does not hold the data itself.

## Interface
- NUM_PARAMS, 20: parameter bytes per full load; address order w00,w01,w02,w03,b0,w10,…,b3.
- NUM_INPUTS, 4: input bytes per run.
- PASSES, 2: array evaluations per run (≥1); passes after the first use fed-back neuron outputs.
- SETTLE, 1: cycles (≥1) allowed for the combinational perceptrons to settle per pass.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  byte present on the shared input bus this cycle.
- load_params  in  1  request a full parameter load; sampled in IDLE only.
- run  in  1  request input load plus compute; sampled in IDLE only.
- param_we  out  1  write the bus byte to parameter register param_addr.
- param_addr  out  5  parameter index, 0..NUM_PARAMS-1.
- input_we  out  1  write the bus byte to input register input_addr.
- input_addr  out  2  input index, 0..NUM_INPUTS-1.
- feedback_we  out  1  load all 4 input registers from the neuron outputs.
- out_we  out  1  capture neuron outputs into the network output register.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- params_ok  out  1  sticky; a complete parameter set is loaded.
- state  out  3  current state encoding, for debug and observation.

## Operation
- States: IDLE=0, LOAD_P=1, LOAD_I=2, SETTLE=3, FEEDBACK=4, DONE=5.
- IDLE:
  - load_params → LOAD_P; clear params_ok and the byte counter.
  - Otherwise run with params_ok=1 → LOAD_I; clear the byte counter and pass counter.
  - load_params wins if both are high.
  - run with params_ok=0 is ignored: stay in IDLE, no done.
- LOAD_P:
  - param_we = byte_valid; param_addr = byte counter.
  - The counter increments on each accepted byte.
  - On the accepted byte at address NUM_PARAMS-1 → IDLE, params_ok←1.
- LOAD_I:
  - input_we = byte_valid; input_addr = byte counter.
  - On the accepted byte at address NUM_INPUTS-1 → SETTLE; reload the settle counter.
- SETTLE:
  - Stays for exactly SETTLE cycles.
  - Then → FEEDBACK if pass < PASSES-1, else → DONE.
- FEEDBACK:
  - feedback_we=1 for one cycle; pass increments.
  - Next state SETTLE, with the settle counter reloaded.
- DONE: out_we=1 and done=1 for one cycle, then → IDLE.
- byte_valid outside LOAD_P/LOAD_I is ignored; no write enables assert.
- load_params/run while busy are ignored; there is no abort other than reset.
- Write enables and addresses are decoded from registered state/counters plus byte_valid. No other combinational paths from inputs to outputs.

## Timing
- Reset, async assert: state=IDLE, counters=0, params_ok=0; every output 0.
- Reset release is synchronous to clk.
- Reset mid-load or mid-compute discards progress. params_ok stays 0 until a new complete parameter load.
- Request to first load cycle: request seen in IDLE at edge k; LOAD_P/LOAD_I is active from cycle k+1.
- Byte write latency is zero: the write enable is high in the same cycle as byte_valid. Back-to-back bytes are accepted every cycle.
- Cycle 1 is the cycle after the edge accepting the last input byte.
  - done is high in cycle PASSES·(SETTLE+1).
  - Default parameters: SETTLE in cycle 1, FEEDBACK in 2, SETTLE in 3, DONE in 4.
- PASSES=1: no FEEDBACK cycles; DONE follows SETTLE directly.
- busy falls in the cycle after DONE; a new run may be sampled in that cycle.

## Structure
- Shared package nn_ctrl_pkg holds:
  - the state enum;
  - constants NUM_PARAMS_DEF=20, NUM_INPUTS_DEF=4 and NEURONS=4;
  - parameter-address helper constants (the b_n index equals 5n+4).
- Single module with inline byte, settle and pass counters; no sub-module needed.
- Replaces the free-running 2-bit state selector; the register files key off its write enables.

## Test plan
- Reset, then load_params plus 20 back-to-back bytes 0x01..0x14:
  - param_addr 0..19 with param_we on each;
  - params_ok=1 and state=IDLE after the 20th byte.
- run with params_ok=0 → state stays 0, no input_we, no done. Then a load, then run with 4 bytes spaced by idle cycles:
  - input_addr 0..3 only on byte_valid cycles;
  - done in cycle 4 after the last byte;
  - feedback_we in cycle 2 only;
  - out_we with done.
- PASSES=3, SETTLE=2: done in cycle 9 after the last input byte; feedback_we in cycles 3 and 6.
- load_params and run pulsed while busy, and byte_valid in SETTLE:
  - no state change and no stray write enables;
  - done timing unchanged.
- rst_n low in LOAD_P after 7 bytes:
  - immediate return to IDLE and outputs 0;
  - params_ok=0, and a subsequent run is ignored.
- load_params and run asserted together in IDLE → LOAD_P entered; run is ignored.
